msc_result_calc: RTL and testbench

- Consumer side of the multi-slope converter's per-conversion count snapshot.
- The converter control logic writes one snapshot at the end of each conversion: the run-up PWM mode counts plus the rundown, N64, P8 and N1 residue counts.
- This block accepts the snapshot with a valid/ready handshake and sequentially reduces it to one signed charge-balance result.
- The result is presented downstream on a second valid/ready interface. Downstream is the serial or host reader.

---
 rtl/msc_pkg.sv | 41 ++++
 rtl/msc_term_sel.sv | 48 ++++
 rtl/msc_result_calc.sv | 121 ++++++++++++
 tb/tb_msc_result_calc.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/msc_pkg.sv
// Shared definitions for the multi-slope converter count snapshot and result reduction.
package msc_pkg;

    localparam int unsigned RU_CNT_W      = 32;
    localparam int unsigned RD_W          = 12;
    localparam int unsigned SLOPE_W       = 8;
    localparam int unsigned RES_W_DEF     = 48;
    localparam int unsigned DROP_W        = 8;
    localparam int unsigned STATE_W       = 3;

    // Slope weights are powers of two: 512 (rundown), 64, 8, 1.
    localparam int unsigned RD_SHIFT      = 9;
    localparam int unsigned N64_SHIFT     = 6;
    localparam int unsigned P8_SHIFT      = 3;
    localparam int unsigned N1_SHIFT      = 0;

    // Run-up charge per PWM period of net imbalance: 250 clocks x 512 LSB.
    localparam int unsigned RU_WEIGHT_DEF = 128000;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        T_RU  = 3'd1,
        T_RD  = 3'd2,
        T_N64 = 3'd3,
        T_P8  = 3'd4,
        T_N1  = 3'd5,
        OUT   = 3'd6
    } msc_state_e;

    typedef struct packed {
        logic [RU_CNT_W-1:0] ru_pos;
        logic [RU_CNT_W-1:0] ru_neg;
        logic [RD_W-1:0]     rd;
        logic [SLOPE_W-1:0]  n64;
        logic [SLOPE_W-1:0]  p8;
        logic [SLOPE_W-1:0]  n1;
    } msc_snap_t;

    localparam int unsigned SNAP_W = $bits(msc_snap_t);

endpackage

// File: rtl/msc_term_sel.sv
// Selects and weights the single snapshot term that the current state contributes.
module msc_term_sel
    import msc_pkg::*;
#(
    parameter int unsigned RES_W     = RES_W_DEF,
    parameter int unsigned RU_WEIGHT = RU_WEIGHT_DEF
) (
    input  logic [STATE_W-1:0] state_i,
    input  logic [SNAP_W-1:0]  snap_i,
    output logic [RES_W-1:0]   term_o
);

    msc_snap_t               snap;
    logic signed [RU_CNT_W:0] ru_diff;
    logic signed [RES_W-1:0]  ru_diff_ext;
    logic [RES_W-1:0]         ru_term;
    logic [RES_W-1:0]         rd_mag;
    logic [RES_W-1:0]         n64_mag;
    logic [RES_W-1:0]         p8_mag;
    logic [RES_W-1:0]         n1_mag;

    assign snap = msc_snap_t'(snap_i);

    // Net run-up imbalance, one bit wider so the difference keeps its sign.
    assign ru_diff     = $signed({1'b0, snap.ru_pos}) - $signed({1'b0, snap.ru_neg});
    assign ru_diff_ext = RES_W'(ru_diff);
    assign ru_term     = ru_diff_ext * $signed(RES_W'(RU_WEIGHT));

    // Residue magnitudes; the sign is applied in the mux below.
    assign rd_mag  = RES_W'(snap.rd)  << RD_SHIFT;
    assign n64_mag = RES_W'(snap.n64) << N64_SHIFT;
    assign p8_mag  = RES_W'(snap.p8)  << P8_SHIFT;
    assign n1_mag  = RES_W'(snap.n1)  << N1_SHIFT;

    // Per-state signed term; idle and output states contribute nothing.
    always_comb begin
        term_o = '0;
        case (msc_state_e'(state_i))
            T_RU:    term_o = ru_term;
            T_RD:    term_o = -rd_mag;
            T_N64:   term_o = n64_mag;
            T_P8:    term_o = -p8_mag;
            T_N1:    term_o = n1_mag;
            default: term_o = '0;
        endcase
    end

endmodule

// File: rtl/msc_result_calc.sv
// Accepts a conversion count snapshot and reduces it, one term per cycle, to a signed result.
module msc_result_calc
    import msc_pkg::*;
#(
    parameter int unsigned RU_WEIGHT = RU_WEIGHT_DEF,
    parameter int unsigned RES_W     = RES_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [RU_CNT_W-1:0] ru_pos,
    input  logic [RU_CNT_W-1:0] ru_neg,
    input  logic [RD_W-1:0]     rd,
    input  logic [SLOPE_W-1:0]  n64,
    input  logic [SLOPE_W-1:0]  p8,
    input  logic [SLOPE_W-1:0]  n1,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RES_W-1:0]    result,
    output logic [DROP_W-1:0]   drop_cnt
);

    msc_state_e        state_q;
    msc_snap_t         snap_q;
    msc_snap_t         snap_in;
    logic [RES_W-1:0]  acc_q;
    logic [RES_W-1:0]  result_q;
    logic              out_valid_q;
    logic [DROP_W-1:0] drop_q;
    logic [RES_W-1:0]  term;
    logic [RES_W-1:0]  acc_sum;

    assign snap_in = {ru_pos, ru_neg, rd, n64, p8, n1};

    msc_term_sel #(
        .RES_W     (RES_W),
        .RU_WEIGHT (RU_WEIGHT)
    ) u_term_sel (
        .state_i (state_q),
        .snap_i  (snap_q),
        .term_o  (term)
    );

    assign acc_sum = acc_q + term;

    // Ready in IDLE, and in OUT exactly when the current result is being taken.
    assign in_ready  = (state_q == IDLE) || ((state_q == OUT) && out_ready);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign drop_cnt  = drop_q;

    // Sequencer: capture snapshot, accumulate five terms, hold result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        snap_q  <= snap_in;
                        acc_q   <= '0;
                        state_q <= T_RU;
                    end
                end
                T_RU: begin
                    acc_q   <= acc_sum;
                    state_q <= T_RD;
                end
                T_RD: begin
                    acc_q   <= acc_sum;
                    state_q <= T_N64;
                end
                T_N64: begin
                    acc_q   <= acc_sum;
                    state_q <= T_P8;
                end
                T_P8: begin
                    acc_q   <= acc_sum;
                    state_q <= T_N1;
                end
                T_N1: begin
                    acc_q       <= acc_sum;
                    result_q    <= acc_sum;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            snap_q  <= snap_in;
                            acc_q   <= '0;
                            state_q <= T_RU;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Counts snapshots lost to back-pressure, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (in_valid && !in_ready && (drop_q != {DROP_W{1'b1}})) begin
            drop_q <= drop_q + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_msc_result_calc.sv
// Randomized and directed checks of msc_result_calc against a cycle-count reference model.
module tb_msc_result_calc;
    import msc_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ru_pos;
    logic [31:0] ru_neg;
    logic [11:0] rd;
    logic [7:0]  n64;
    logic [7:0]  p8;
    logic [7:0]  n1;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] result;
    logic [7:0]  drop_cnt;

    int n_cmp;
    int n_err;

    // Reference model: cycles left until the in-flight result appears, pending outputs.
    int          m_busy;
    logic        m_ov;
    logic [47:0] m_last;
    logic [47:0] m_pend;
    int          m_drop;

    msc_result_calc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ru_pos    (ru_pos),
        .ru_neg    (ru_neg),
        .rd        (rd),
        .n64       (n64),
        .p8        (p8),
        .n1        (n1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Charge-balance result from plain integer arithmetic, wrapped to 48 bits.
    function automatic logic [47:0] ref_res(input msc_snap_t s);
        longint r;
        r = 64'sd128000 * (longint'(s.ru_pos) - longint'(s.ru_neg))
            - 64'sd512 * longint'(s.rd)
            + 64'sd64  * longint'(s.n64)
            - 64'sd8   * longint'(s.p8)
            + longint'(s.n1);
        return r[47:0];
    endfunction

    function automatic msc_snap_t rand_snap();
        msc_snap_t s;
        int mode;
        mode = $urandom_range(0, 3);
        s.ru_pos = $urandom();
        s.ru_neg = $urandom();
        s.rd     = 12'($urandom());
        s.n64    = 8'($urandom());
        s.p8     = 8'($urandom());
        s.n1     = 8'($urandom());
        if (mode == 1) begin
            s.ru_pos = $urandom_range(0, 20);
            s.ru_neg = $urandom_range(0, 20);
        end else if (mode == 2) begin
            s = '0;
        end
        return s;
    endfunction

    // One clock cycle: drive, check outputs against the model, advance the model.
    task automatic cycle(input logic v, input msc_snap_t s, input logic ordy);
        logic exp_ir;
        in_valid  = v;
        ru_pos    = s.ru_pos;
        ru_neg    = s.ru_neg;
        rd        = s.rd;
        n64       = s.n64;
        p8        = s.p8;
        n1        = s.n1;
        out_ready = ordy;
        #1;
        exp_ir = ((m_busy == 0) && !m_ov) || (m_ov && ordy);
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("in_ready",  64'(in_ready),  64'(exp_ir));
        chk("result",    64'(result),    64'(m_last));
        chk("drop_cnt",  64'(drop_cnt),  64'(m_drop));
        if (v && !exp_ir && m_drop < 255) m_drop++;
        if (m_ov && ordy) m_ov = 1'b0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_ov   = 1'b1;
                m_last = m_pend;
            end
        end
        if (v && exp_ir) begin
            m_busy = 5;
            m_pend = ref_res(s);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_ov   = 1'b0;
        m_last = '0;
        m_pend = '0;
        m_drop = 0;
    endtask

    msc_snap_t   zs;
    msc_snap_t   nom;
    msc_snap_t   neg;
    msc_snap_t   sb;
    logic [47:0] neg_exp;

    initial begin
        n_cmp = 0;
        n_err = 0;
        zs    = '0;
        model_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        ru_pos = '0; ru_neg = '0; rd = '0; n64 = '0; p8 = '0; n1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result",    64'(result),    64'd0);
        chk("rst_drop",      64'(drop_cnt),  64'd0);
        rst = 1'b0;

        // Nominal snapshot.
        nom = '{ru_pos: 32'd10, ru_neg: 32'd8, rd: 12'd100, n64: 8'd3, p8: 8'd5, n1: 8'd7};
        cycle(1'b1, nom, 1'b0);
        repeat (5) cycle(1'b0, zs, 1'b0);
        chk("nom_valid",  64'(out_valid), 64'd1);
        chk("nom_result", 64'(result),    64'd204959);
        cycle(1'b0, zs, 1'b1);

        // Negative result, sign-extended.
        neg = '{ru_pos: 32'd0, ru_neg: 32'd2, rd: 12'd4095, n64: 8'd0, p8: 8'd0, n1: 8'd0};
        neg_exp = 48'(-64'sd2352640);
        cycle(1'b1, neg, 1'b0);
        repeat (5) cycle(1'b0, zs, 1'b0);
        chk("neg_result", 64'(result), 64'(neg_exp));
        cycle(1'b0, zs, 1'b1);

        // All-zero snapshot.
        cycle(1'b1, zs, 1'b0);
        repeat (5) cycle(1'b0, zs, 1'b0);
        chk("zero_result", 64'(result), 64'd0);
        cycle(1'b0, zs, 1'b1);

        // Back-pressure in OUT with three dropped snapshots.
        cycle(1'b1, nom, 1'b0);
        repeat (5) cycle(1'b0, zs, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle((i == 3) || (i == 9) || (i == 15), rand_snap(), 1'b0);
            chk("bp_result", 64'(result), 64'd204959);
        end
        chk("bp_drop", 64'(drop_cnt), 64'd3);
        cycle(1'b0, zs, 1'b1);
        chk("bp_idle_ready", 64'(in_ready),  64'd1);
        chk("bp_idle_valid", 64'(out_valid), 64'd0);

        // Back-to-back: new snapshot accepted in the first OUT cycle.
        cycle(1'b1, neg, 1'b1);
        repeat (5) cycle(1'b0, zs, 1'b1);
        sb = rand_snap();
        cycle(1'b1, sb, 1'b1);
        repeat (5) cycle(1'b0, zs, 1'b1);
        chk("b2b_valid",  64'(out_valid), 64'd1);
        chk("b2b_result", 64'(result),    64'(ref_res(sb)));
        cycle(1'b0, zs, 1'b1);

        // Saturating drop counter.
        cycle(1'b1, nom, 1'b0);
        repeat (5) cycle(1'b0, zs, 1'b0);
        repeat (300) cycle(1'b1, rand_snap(), 1'b0);
        chk("sat_drop", 64'(drop_cnt), 64'd255);
        cycle(1'b0, zs, 1'b1);

        // Reset during T_P8 aborts the conversion.
        cycle(1'b1, neg, 1'b0);
        repeat (3) cycle(1'b0, zs, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
        chk("mid_rst_result",    64'(result),    64'd0);
        chk("mid_rst_drop",      64'(drop_cnt),  64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b1, nom, 1'b0);
        repeat (5) cycle(1'b0, zs, 1'b0);
        chk("post_rst_result", 64'(result), 64'd204959);
        cycle(1'b0, zs, 1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 2) == 0), rand_snap(), ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
